// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer. One full-adder cell is time-shared across
// a WIDTH-bit operation, processing one bit per clock, LSB first. Operands are
// captured on start; the result, carry-out and signed overflow are registered
// at the completion edge, and done pulses for one cycle.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Shared one-bit full-adder cell
    logic cell_a, cell_b, cell_cin, cell_sum, cell_cout;

    // Full-adder cell: operates on the current LSBs and the running carry
    always_comb begin
        cell_a    = opa_q[0];
        cell_b    = opb_q[0];
        cell_cin  = carry_q;
        cell_sum  = cell_a ^ cell_b ^ cell_cin;
        cell_cout = (cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin);
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    opa_d   = a_i;
                    // Subtraction is a + ~b + 1: invert b, seed carry with 1
                    opb_d   = sub_i ? ~b_i : b_i;
                    carry_d = sub_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum bit enters at the MSB so after WIDTH shifts bit 0 lands at LSB
                acc_d   = {cell_sum, acc_q[WIDTH-1:1]};
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                carry_d = cell_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    result_d = {cell_sum, acc_q[WIDTH-1:1]};
                    cout_d   = cell_cout;
                    // carry_q is the carry into the MSB at this edge
                    ovf_d    = carry_q ^ cell_cout;
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        busy_o     = (state_q == StRun) || (state_q == StDone);
        done_o     = (state_q == StDone);
        result_o   = result_q;
        cout_o     = cout_q;
        overflow_o = ovf_q;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer that time-shares one internally instantiated one-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first.
- Accepts operands with a start pulse and returns a registered result, carry-out and signed overflow with a one-cycle done strobe.
- Used where area matters more than latency: one adder cell plus shift registers replace a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion strobe
result  output  WIDTH  registered sum/difference
cout  output  1  final carry out; for sub, 1 = no borrow
overflow  output  1  two's-complement overflow of the completed operation

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. busy, done, result, cout and overflow all = 0. Internal shift registers, carry and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: opA <= a; opB <= (sub ? ~b : b); carry <= sub; cnt <= 0; state -> RUN.
  - start=0: remain in IDLE.
- RUN, one bit per edge:
  - The adder cell sees opA[0], opB[0] and carry.
  - Its sum bit shifts into the MSB of the internal accumulator; opA and opB shift right by one; carry <= cell carry-out; cnt increments.
  - At the edge where cnt = WIDTH-1, the last bit is processed and state -> DONE.
  - At that same edge: result <= final accumulator; cout <= final carry; overflow <= (carry into MSB) XOR (carry out of MSB).
  - The carry into the MSB is the carry register value at that edge.
- DONE: done = 1 for exactly one cycle; next edge -> IDLE.
- Latency: if start is sampled at edge T0, bits are processed at edges T1..T_WIDTH. done is high during the cycle following edge T_WIDTH. busy falls at edge T_WIDTH+1. Next start is accepted at T_WIDTH+1 at the earliest.
- busy and done are decoded from registered state only (Moore); no combinational path from inputs to outputs.
- result, cout and overflow change only at the completion edge. They hold their value through IDLE and through the next operation until that operation completes.
- Boundary conditions:
  - start while busy (RUN or DONE): ignored, no queuing.
  - a, b, sub changing after the sampling edge: no effect on the operation in flight.
  - start held high continuously: back-to-back operations, one accepted each time the FSM re-enters IDLE (period WIDTH+2 cycles).
  - Carry wraps out of the result: reported on cout; result is modulo 2^WIDTH.
  - rst_n asserted mid-RUN: operation aborted, no done pulse, outputs cleared to 0.
  - rst_n deasserted with start=1: start is sampled at the first rising edge after deassertion.
- Arithmetic: subtraction is a + ~b + 1. All arithmetic is WIDTH bits, unsigned result. overflow uses signed interpretation of a and b.
- Bit counter width: clog2(WIDTH).

Test Plan (WIDTH=8):
- Basic add: start, sub=0, a=0x35, b=0x4A -> done exactly 8 cycles after the start edge, one cycle wide; result=0x7F, cout=0, overflow=0.
- Add wrap and signed overflow:
  - a=0xFF, b=0x01 -> result=0x00, cout=1, overflow=0.
  - Then a=0x7F, b=0x01 -> result=0x80, cout=0, overflow=1.
- Subtract with borrow and signed overflow:
  - sub=1, a=0x10, b=0x20 -> result=0xF0, cout=0, overflow=0.
  - Then a=0x80, b=0x01 -> result=0x7F, cout=1, overflow=1.
- Protocol: start pulsed again 3 cycles into an operation with different operands -> ignored; first result intact; busy stays high until 1 cycle after done; start held high -> accepted every 10 cycles.
- Operand change mid-op: a and b changed every cycle during RUN -> result matches the values sampled at start.
- Reset mid-op: rst_n low at cycle 4 of RUN -> all outputs 0 immediately (asynchronous), no done pulse; a fresh op after release gives the correct result (0x35+0x4A=0x7F).
